// File: rtl/fx_cmd_parser.sv
// fx_cmd_parser: decodes host command packets into fx bus write/read bursts
module fx_cmd_parser #(
    parameter int RD_LAT  = 1,
    parameter int TIMEOUT = 65535
) (
    input  logic        clk_sys,
    input  logic        rst_n,
    input  logic [5:0]  dev_id,
    input  logic [7:0]  rx_data,
    input  logic        rx_vld,
    output logic        rx_rdy,
    output logic [7:0]  tx_data,
    output logic        tx_vld,
    input  logic        tx_rdy,
    output logic [21:0] fx_waddr,
    output logic        fx_wr,
    output logic [7:0]  fx_data,
    output logic        fx_rd,
    output logic [21:0] fx_raddr,
    input  logic [7:0]  fx_q,
    output logic        busy,
    output logic [7:0]  err_cnt
);
    typedef enum logic [3:0] {IDLE, DEV, ADR2, ADR1, ADR0, LEN, WDAT, RISSUE, RWAIT, RSEND} state_t;
    state_t state, state_nxt;
    logic        accept, err, match, is_wr, op_ok, timed;
    logic [21:0] addr;
    logic [8:0]  cnt;
    logic [15:0] tmo;
    logic [2:0]  lat;
    assign accept = rx_vld & rx_rdy;
    assign busy   = state != IDLE;
    assign op_ok  = rx_data == 8'h57 || rx_data == 8'h52;
    assign timed  = state inside {DEV, ADR2, ADR1, ADR0, LEN, WDAT};
    // state register
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end
    // next state and error pulse; a stalled packet aborts back to IDLE
    always_comb begin
        state_nxt = state;
        err       = 1'b0;
        case (state)
            IDLE: if (accept) begin
                state_nxt = op_ok ? DEV : IDLE;
                err       = !op_ok;
            end
            DEV: if (accept) begin
                state_nxt = rx_data[7:6] == 2'b00 ? ADR2 : IDLE;
                err       = rx_data[7:6] != 2'b00;
            end
            ADR2:    state_nxt = accept ? ADR1 : ADR2;
            ADR1:    state_nxt = accept ? ADR0 : ADR1;
            ADR0:    state_nxt = accept ? LEN : ADR0;
            LEN:     if (accept) state_nxt = is_wr ? WDAT : (match ? RISSUE : IDLE);
            WDAT:    if (accept && cnt == 9'd1) state_nxt = IDLE;
            RISSUE:  state_nxt = RWAIT;
            RWAIT:   if (lat == 3'(RD_LAT)) state_nxt = RSEND;
            RSEND:   if (tx_rdy) state_nxt = cnt == 9'd1 ? IDLE : RISSUE;
            default: state_nxt = IDLE;
        endcase
        if (timed && !accept && tmo == 16'(TIMEOUT - 1)) begin
            state_nxt = IDLE;
            err       = 1'b1;
        end
    end
    // datapath: header capture, write strobes, read issue/capture/return, error count
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            rx_rdy   <= 1'b0;
            tx_data  <= '0;
            tx_vld   <= 1'b0;
            fx_waddr <= '0;
            fx_wr    <= 1'b0;
            fx_data  <= '0;
            fx_rd    <= 1'b0;
            fx_raddr <= '0;
            err_cnt  <= '0;
            match    <= 1'b0;
            is_wr    <= 1'b0;
            addr     <= '0;
            cnt      <= '0;
            tmo      <= '0;
            lat      <= '0;
        end else begin
            rx_rdy  <= state_nxt inside {IDLE, DEV, ADR2, ADR1, ADR0, LEN, WDAT};
            fx_wr   <= 1'b0;
            fx_rd   <= 1'b0;
            err_cnt <= (err && err_cnt != 8'hFF) ? err_cnt + 8'd1 : err_cnt;
            tmo     <= (accept || !(state_nxt inside {DEV, ADR2, ADR1, ADR0, LEN, WDAT})) ? '0 : tmo + 16'd1;
            case (state)
                IDLE: if (accept) is_wr <= rx_data == 8'h57;
                DEV:  if (accept) match <= rx_data[5:0] == dev_id;
                ADR2: if (accept) addr[21:16] <= rx_data[5:0];
                ADR1: if (accept) addr[15:8] <= rx_data;
                ADR0: if (accept) addr[7:0] <= rx_data;
                LEN:  if (accept) cnt <= {rx_data == 8'h00, rx_data};
                WDAT: if (accept) begin
                    fx_wr <= match;
                    if (match) begin
                        fx_data  <= rx_data;
                        fx_waddr <= addr;
                    end
                    addr <= addr + 22'd1;
                    cnt  <= cnt - 9'd1;
                end
                RISSUE: begin
                    fx_rd    <= 1'b1;
                    fx_raddr <= addr;
                    lat      <= '0;
                end
                RWAIT: begin
                    lat <= lat + 3'd1;
                    if (state_nxt == RSEND) begin
                        tx_data <= fx_q;
                        tx_vld  <= 1'b1;
                    end
                end
                RSEND: if (tx_rdy) begin
                    tx_vld <= 1'b0;
                    addr   <= addr + 22'd1;
                    cnt    <= cnt - 9'd1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fx_cmd_parser.sv
// tb_fx_cmd_parser: randomized packet-level checking of fx_cmd_parser against a transaction model
module tb_fx_cmd_parser;
    localparam int RD_LAT  = 1;
    localparam int TIMEOUT = 100;
    logic        clk_sys = 1'b0;
    logic        rst_n = 1'b1;
    logic [5:0]  dev_id = 6'h05;
    logic [7:0]  rx_data = '0;
    logic        rx_vld = 1'b0;
    logic        rx_rdy;
    logic [7:0]  tx_data;
    logic        tx_vld;
    logic        tx_rdy = 1'b1;
    logic [21:0] fx_waddr, fx_raddr;
    logic        fx_wr, fx_rd, busy;
    logic [7:0]  fx_data, err_cnt;
    logic [7:0]  fx_q = '0;
    logic        tx_fix = 1'b1, tx_rand = 1'b0;
    logic        stall = 1'b0;
    logic [7:0]  hold_d = '0;
    logic [29:0] ew[$], wq[$];
    logic [21:0] er[$], rq[$];
    logic [7:0]  et[$], tq[$], dq[$];
    int          wc[$];
    int          cyc = 0, em_err = 0, vectors = 0, miscompares = 0;

    fx_cmd_parser #(.RD_LAT(RD_LAT), .TIMEOUT(TIMEOUT)) dut (
        .clk_sys(clk_sys), .rst_n(rst_n), .dev_id(dev_id),
        .rx_data(rx_data), .rx_vld(rx_vld), .rx_rdy(rx_rdy),
        .tx_data(tx_data), .tx_vld(tx_vld), .tx_rdy(tx_rdy),
        .fx_waddr(fx_waddr), .fx_wr(fx_wr), .fx_data(fx_data),
        .fx_rd(fx_rd), .fx_raddr(fx_raddr), .fx_q(fx_q),
        .busy(busy), .err_cnt(err_cnt)
    );

    always #5 clk_sys = ~clk_sys;
    always @(posedge clk_sys) cyc <= cyc + 1;
    // register-file model: returns addr[7:0]^0x5A one cycle after fx_rd, garbage otherwise
    always @(posedge clk_sys) fx_q <= fx_rd ? (fx_raddr[7:0] ^ 8'h5A) : 8'hEE;
    // tx sink readiness, either fixed or random
    always @(posedge clk_sys) begin
        #1;
        tx_rdy = tx_rand ? ($urandom_range(0, 2) != 0) : tx_fix;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // bus monitor
    always @(negedge clk_sys) if (rst_n) begin
        if (fx_wr) begin
            wq.push_back({fx_waddr, fx_data});
            wc.push_back(cyc);
        end
        if (fx_rd) rq.push_back(fx_raddr);
        if (tx_vld && tx_rdy) tq.push_back(tx_data);
        if (fx_wr || fx_rd) check("wr_rd_exclusive", {31'd0, fx_wr & fx_rd}, 0);
        if (stall) begin
            check("tx_vld_hold", {31'd0, tx_vld}, 1);
            check("tx_data_hold", {24'd0, tx_data}, {24'd0, hold_d});
        end
        stall  = tx_vld & ~tx_rdy;
        hold_d = tx_data;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic send(input logic [7:0] b, input bit gap);
        bit ok;
        int n;
        if (gap) begin
            rx_vld = 1'b0;
            n = $urandom_range(0, 3);
            repeat (n) begin @(posedge clk_sys); #1; end
        end
        rx_data = b;
        rx_vld  = 1'b1;
        n = 0;
        do begin
            @(negedge clk_sys);
            ok = rx_rdy;
            @(posedge clk_sys);
            #1;
            n++;
        end while (!ok && n < 3000);
        if (!ok) check("rx_accept_timeout", 0, 1);
    endtask

    task automatic idle(input int n);
        rx_vld = 1'b0;
        repeat (n) begin @(posedge clk_sys); #1; end
    endtask

    task automatic wait_idle();
        int n = 0;
        rx_vld = 1'b0;
        while (busy && n < 5000) begin @(posedge clk_sys); #1; n++; end
        if (busy) check("busy_timeout", {31'd0, busy}, 0);
        idle(3);
    endtask

    task automatic pkt(input bit wr, input logic [7:0] dv, input logic [23:0] a,
                       input logic [7:0] len, input bit gap, input bit stl);
        int n, l;
        bit m;
        logic [21:0] x;
        logic [7:0] d;
        l = (len == 8'd0) ? 256 : int'(len);
        m = dv[5:0] == dev_id;
        send(wr ? 8'h57 : 8'h52, gap);
        send(dv, gap);
        send(a[23:16], gap);
        send(a[15:8], gap);
        send(a[7:0], gap);
        send(len, gap);
        for (int i = 0; i < l; i++) begin
            x = a[21:0] + 22'(i);
            if (wr) begin
                d = dq.size() != 0 ? dq.pop_front() : 8'($urandom);
                send(d, gap);
                if (m) ew.push_back({x, d});
            end else if (m) begin
                er.push_back(x);
                et.push_back(x[7:0] ^ 8'h5A);
            end
        end
        if (stl) begin
            rx_vld = 1'b0;
            n = 0;
            while (!tx_vld && n < 100) begin @(posedge clk_sys); #1; n++; end
            check("tx_vld_seen", {31'd0, tx_vld}, 1);
            repeat (5) begin @(posedge clk_sys); #1; end
            tx_fix = 1'b1;
        end
        wait_idle();
    endtask

    task automatic compare();
        check("wr_count", wq.size(), ew.size());
        for (int i = 0; i < wq.size() && i < ew.size(); i++) check("wr_addr_data", {2'd0, wq[i]}, {2'd0, ew[i]});
        check("rd_count", rq.size(), er.size());
        for (int i = 0; i < rq.size() && i < er.size(); i++) check("rd_addr", {10'd0, rq[i]}, {10'd0, er[i]});
        check("tx_count", tq.size(), et.size());
        for (int i = 0; i < tq.size() && i < et.size(); i++) check("tx_byte", {24'd0, tq[i]}, {24'd0, et[i]});
        check("err_cnt", {24'd0, err_cnt}, em_err > 255 ? 255 : em_err);
        ew.delete(); wq.delete(); er.delete(); rq.delete(); et.delete(); tq.delete(); wc.delete();
    endtask

    initial begin
        logic [7:0] b;
        int r;
        #1 rst_n = 1'b0;
        #6;
        check("rst_rx_rdy", {31'd0, rx_rdy}, 0);
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_strobes", {29'd0, fx_wr, fx_rd, tx_vld}, 0);
        check("rst_err_cnt", {24'd0, err_cnt}, 0);
        check("rst_waddr", {10'd0, fx_waddr}, 0);
        check("rst_raddr", {10'd0, fx_raddr}, 0);
        check("rst_data", {16'd0, fx_data, tx_data}, 0);
        #15 rst_n = 1'b1;
        @(posedge clk_sys); #1;
        check("rx_rdy_after_release", {31'd0, rx_rdy}, 1);

        dq = '{8'hAA, 8'hBB, 8'hCC};
        pkt(1'b1, 8'h05, 24'h001000, 8'd3, 1'b0, 1'b0);
        check("burst_span", wc.size() == 3 ? wc[2] - wc[0] : 99, 2);
        compare();

        tx_fix = 1'b0;
        pkt(1'b0, 8'h05, 24'h000020, 8'd2, 1'b0, 1'b1);
        compare();

        dq = '{8'h11, 8'h22};
        pkt(1'b1, 8'h05, 24'h3FFFFF, 8'd2, 1'b0, 1'b0);
        compare();

        pkt(1'b1, 8'h06, 24'h000100, 8'd4, 1'b0, 1'b0);
        compare();
        pkt(1'b0, 8'h06, 24'h000100, 8'd2, 1'b0, 1'b0);
        check("filtered_rd_idle", {30'd0, busy, tx_vld}, 0);
        compare();

        send(8'h00, 1'b0);
        send(8'h57, 1'b0);
        send(8'hC5, 1'b0);
        em_err += 2;
        wait_idle();
        compare();

        send(8'h57, 1'b0);
        send(8'h05, 1'b0);
        send(8'h00, 1'b0);
        idle(TIMEOUT - 1);
        check("timeout_not_yet", {31'd0, busy}, 1);
        idle(1);
        check("timeout_abort", {31'd0, busy}, 0);
        em_err++;
        compare();

        pkt(1'b1, 8'h05, 24'($urandom), 8'd0, 1'b0, 1'b0);
        compare();

        tx_rand = 1'b1;
        for (int k = 0; k < 40; k++) begin
            r = $urandom_range(0, 9);
            if (r == 0) begin
                b = 8'($urandom);
                if (b == 8'h57 || b == 8'h52) b = 8'h00;
                send(b, 1'b1);
                em_err++;
                wait_idle();
            end else if (r == 1) begin
                send(8'h57, 1'b1);
                send({2'($urandom_range(1, 3)), 6'($urandom)}, 1'b1);
                em_err++;
                wait_idle();
            end else begin
                pkt(1'($urandom), $urandom_range(0, 9) < 7 ? 8'h05 : {2'b00, 6'($urandom)},
                    24'($urandom), 8'($urandom_range(1, 8)), 1'b1, 1'b0);
            end
            compare();
        end
        tx_rand = 1'b0;
        tx_fix  = 1'b1;

        send(8'h57, 1'b0);
        send(8'h05, 1'b0);
        send(8'h00, 1'b0);
        send(8'h02, 1'b0);
        send(8'h00, 1'b0);
        send(8'd20, 1'b0);
        for (int i = 0; i < 10; i++) begin
            b = 8'($urandom);
            send(b, 1'b0);
            ew.push_back({22'h000200 + 22'(i), b});
        end
        rx_vld = 1'b0;
        @(posedge clk_sys); #1;
        rst_n = 1'b0;
        #1;
        check("midrst_strobes", {29'd0, fx_wr, fx_rd, tx_vld}, 0);
        check("midrst_busy_rdy", {30'd0, busy, rx_rdy}, 0);
        check("midrst_err_cnt", {24'd0, err_cnt}, 0);
        em_err = 0;
        #10 rst_n = 1'b1;
        idle(20);
        compare();
        repeat (3) send(8'h11, 1'b0);
        em_err += 3;
        wait_idle();
        compare();

        for (int i = 0; i < 300; i++) send(8'h00, 1'b0);
        em_err += 300;
        wait_idle();
        compare();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/fx_cmd_parser.md
Name: fx_cmd_parser

Overview:
- Upstream feeder of the fx bus that drives the configuration register block.
- Takes a byte stream from the host link, already synchronised to clk_sys, and decodes command packets.
- Write packets become fx_wr bursts; read packets become fx_rd bursts, and the returned fx_q bytes go back on a byte stream.
- Filters packets by dev_id, recovers from malformed or stalled packets, and counts errors.

Parameters:
- RD_LAT, 1: cycles from the fx_rd assertion edge to valid fx_q; legal range 1..4.
- TIMEOUT, 65535: idle cycles allowed mid-packet before abort; held in a 16-bit counter.

Ports:
- clk_sys  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- dev_id  in  6  board device id.
- rx_data  in  8  incoming command byte.
- rx_vld  in  1  rx_data valid.
- rx_rdy  out  1  parser accepts a byte; a byte transfers when rx_vld & rx_rdy.
- tx_data  out  8  read-back byte.
- tx_vld  out  1  tx_data valid.
- tx_rdy  in  1  sink accepts a byte; a byte transfers when tx_vld & tx_rdy.
- fx_waddr  out  22  write address.
- fx_wr  out  1  one-cycle write strobe.
- fx_data  out  8  write data.
- fx_rd  out  1  one-cycle read strobe.
- fx_raddr  out  22  read address.
- fx_q  in  8  read data, valid RD_LAT cycles after fx_rd.
- busy  out  1  high whenever state != IDLE.
- err_cnt  out  8  saturating error count.

Behaviour:
- Clock and reset: one clock, clk_sys; reset rst_n is asynchronous, active-low.
- Reset values:
  - every output is 0, including rx_rdy; err_cnt = 0; state = IDLE.
  - The first cycle after reset release has rx_rdy = 1.
- Packet format:
  - B0: opcode, 0x57 = write, 0x52 = read.
  - B1: device byte; [7:6] must be 00; [5:0] is compared with dev_id.
  - B2..B4: address A[23:0], big-endian; A[23:22] ignored.
  - B5: length L; L = 0 means 256.
  - Write packets are then followed by L data bytes.
- States: IDLE, DEV, ADR2, ADR1, ADR0, LEN, WDAT, RISSUE, RWAIT, RSEND.
- rx_rdy:
  - 1 in IDLE, DEV, ADR2, ADR1, ADR0, LEN, WDAT.
  - 0 in RISSUE, RWAIT, RSEND.
- Header path:
  - IDLE: opcode 0x57/0x52 → DEV. Any other byte is dropped, err_cnt += 1, stay in IDLE.
  - DEV: [7:6] != 00 → IDLE, err_cnt += 1. Otherwise latch match = (byte[5:0] == dev_id), then → ADR2.
  - ADR2 → ADR1 → ADR0 → LEN, latching one address byte per accepted byte.
  - LEN: loads a 9-bit remaining count. Write → WDAT. Read with match → RISSUE. Read without match → IDLE, no response.
- Write (WDAT):
  - Byte accepted at cycle n → at cycle n+1: fx_wr = 1, fx_data = byte, fx_waddr = current address.
  - Then address += 1 modulo 2^22 and count -= 1.
  - Count reaching 0 → IDLE.
  - match = 0: bytes are consumed, fx_wr stays 0.
  - Full rate is one write per cycle.
- Read:
  - RISSUE: fx_rd = 1 for exactly one cycle with fx_raddr = current address, then → RWAIT.
  - RWAIT: capture fx_q exactly RD_LAT cycles after the fx_rd cycle into tx_data, then → RSEND.
  - RSEND: tx_vld = 1, tx_data held stable until tx_rdy. On transfer: tx_vld = 0, address += 1, count -= 1.
  - After the transfer: → RISSUE if count != 0, else → IDLE.
  - Only one read is outstanding at a time.
- Timeout:
  - In DEV..LEN and WDAT, a 16-bit counter increments every cycle without an accepted byte and clears on every accepted byte.
  - Reaching TIMEOUT → IDLE, err_cnt += 1.
  - There is no timeout on tx backpressure.
- err_cnt: saturates at 255. Simultaneous error sources in one cycle add 1.
- fx_wr and fx_rd are never high in the same cycle.
- fx_waddr and fx_raddr hold their last value between strobes.
- Reset mid-packet: immediate return to IDLE, all strobes 0, tx_vld 0, no partial write after release.

Test Plan:
- Write burst, dev_id = 0x05. Send 57 05 00 10 00 03 AA BB CC with rx_vld held high.
  → fx_wr on 3 consecutive cycles at addresses 0x001000/1/2 with data AA/BB/CC; busy falls after the last byte.
- Read with backpressure, RD_LAT = 1. Send 52 05 00 00 20 02; fx_q model returns addr[7:0] ^ 0x5A; tx_rdy low for 5 cycles, then high.
  → one fx_rd per byte at 0x000020 then 0x000021; tx bytes 7A then 7B; tx_data stable while stalled.
- Address wrap. Write 57 05 3F FF FF 02 11 22.
  → writes at 0x3FFFFF then 0x000000.
- Device filtering.
  - Write with device byte 06 while dev_id = 05: all bytes consumed, no fx_wr.
  - Read with device byte 06: no fx_rd, no tx_vld, parser back in IDLE.
- Errors.
  - Bytes 00 then 57 C5: err_cnt = 2, parser in IDLE.
  - Header 57 05 00 then silence with TIMEOUT = 100: abort after 100 cycles, err_cnt = 3.
  - 300 bad bytes: err_cnt = 255.
- Length and reset.
  - Length byte 00 with 256 data bytes → exactly 256 fx_wr.
  - rst_n pulsed low after the 10th data byte of another burst → outputs 0 immediately; no fx_wr after release until a new packet.
